// File: rtl/explosion_pkg.sv
// Shared types and restart-key decode for the explosion animation sequencer.
package explosion_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StGameOver
    } ch_state_e;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_W     = 8'h1A;

    function automatic logic key_match(input logic [7:0] code);
        return (code == KEY_ENTER) || (code == KEY_SPACE) || (code == KEY_W);
    endfunction

    // Two HID keycodes are reported at once; either slot may carry the restart key.
    function automatic logic is_restart_key(input logic [15:0] keycode);
        return key_match(keycode[7:0]) || key_match(keycode[15:8]);
    endfunction

endpackage

// File: rtl/explosion_channel.sv
// One explosion channel: frame/tick counters and an IDLE/RUN/GAME_OVER state machine.
module explosion_channel
    import explosion_pkg::*;
#(
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned FRAME_TICKS = 8,
    parameter int unsigned RETRIGGER   = 0,
    parameter int unsigned HAS_GO      = 0,
    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int unsigned CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          explode,
    input  logic          restart,
    output logic          active,
    output logic [FW-1:0] frame_idx,
    output logic          done,
    output logic          game_over
);

    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
    localparam logic [CW-1:0] LAST_TICK  = CW'(FRAME_TICKS - 1);

    ch_state_e     state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            frame_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A tick arriving with the start request is deliberately not counted.
                if (explode) begin
                    state_d = StRun;
                    frame_d = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (explode && (RETRIGGER != 0)) begin
                    frame_d = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == LAST_TICK) begin
                        cnt_d = '0;
                        if (frame_q == LAST_FRAME) begin
                            frame_d = '0;
                            done_d  = 1'b1;
                            state_d = (HAS_GO != 0) ? StGameOver : StIdle;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StGameOver: begin
                if (restart) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active    = (state_q == StRun);
        game_over = (state_q == StGameOver);
        frame_idx = frame_q;
        done      = done_q;
    end

endmodule

// File: rtl/explosion_seq.sv
// Multi-channel explosion sequencer; channel 0 is the player and may latch game-over.
module explosion_seq
    import explosion_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned FRAME_TICKS = 8,
    parameter int unsigned RETRIGGER   = 0,
    parameter int unsigned PLAYER_GO   = 1,
    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 tick,
    input  logic [NUM_CH-1:0]    explode,
    input  logic [15:0]          keycode,
    output logic [NUM_CH-1:0]    active,
    output logic [NUM_CH*FW-1:0] frame_idx,
    output logic [NUM_CH-1:0]    done,
    output logic                 game_over
);

    logic              restart_key;
    logic [NUM_CH-1:0] ch_game_over;

    assign restart_key = is_restart_key(keycode);
    // Only the player channel can ever be in game-over.
    assign game_over   = ch_game_over[0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        explosion_channel #(
            .NUM_FRAMES  (NUM_FRAMES),
            .FRAME_TICKS (FRAME_TICKS),
            .RETRIGGER   (RETRIGGER),
            .HAS_GO      (((i == 0) && (PLAYER_GO != 0)) ? 1 : 0)
        ) u_ch (
            .clk       (Clk),
            .rst_n     (Reset),
            .tick      (tick),
            .explode   (explode[i]),
            .restart   ((i == 0) ? restart_key : 1'b0),
            .active    (active[i]),
            .frame_idx (frame_idx[i*FW +: FW]),
            .done      (done[i]),
            .game_over (ch_game_over[i])
        );
    end

endmodule

// File: tb/tb_explosion_seq.sv
// Scoreboard bench: dut 0 uses defaults, dut 1 uses RETRIGGER=1 and PLAYER_GO=0.
module tb_explosion_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] explode;
    logic [15:0] keycode;

    logic [3:0] active_s [2];
    logic [7:0] frame_s  [2];
    logic [3:0] done_s   [2];
    logic       go_s     [2];

    int checks = 0;
    int errors = 0;
    int n = 0;               // ticks issued so far
    int exp_q [2][4][$];     // expected tick count at each done pulse

    always #5 clk = ~clk;

    explosion_seq u_dut0 (
        .Clk       (clk),
        .Reset     (rst_n),
        .tick      (tick),
        .explode   (explode),
        .keycode   (keycode),
        .active    (active_s[0]),
        .frame_idx (frame_s[0]),
        .done      (done_s[0]),
        .game_over (go_s[0])
    );

    explosion_seq #(
        .RETRIGGER (1),
        .PLAYER_GO (0)
    ) u_dut1 (
        .Clk       (clk),
        .Reset     (rst_n),
        .tick      (tick),
        .explode   (explode),
        .keycode   (keycode),
        .active    (active_s[1]),
        .frame_idx (frame_s[1]),
        .done      (done_s[1]),
        .game_over (go_s[1])
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int fr(input int d, input int ch);
        return int'(frame_s[d][ch*2 +: 2]);
    endfunction

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        n++;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int k);
        repeat (k) do_tick();
    endtask

    task automatic pulse(input logic [3:0] m, input logic t);
        @(negedge clk);
        explode = m;
        tick = t;
        if (t) n++;
        @(negedge clk);
        explode = '0;
        tick = 1'b0;
    endtask

    task automatic expect_done(input int d, input int ch, input int t);
        exp_q[d][ch].push_back(t);
    endtask

    // Monitor: pops the scoreboard whenever any channel presents done.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (done_s[d][ch]) begin
                        if (exp_q[d][ch].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done dut%0d ch%0d: got done at tick %0d, expected none",
                                     d, ch, n);
                        end else begin
                            e = exp_q[d][ch].pop_front();
                            check($sformatf("done_tick dut%0d ch%0d", d, ch), n, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        explode = '0;
        keycode = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_active dut%0d", d), int'(active_s[d]), 0);
            check($sformatf("rst_frame dut%0d", d), int'(frame_s[d]), 0);
            check($sformatf("rst_done dut%0d", d), int'(done_s[d]), 0);
            check($sformatf("rst_go dut%0d", d), int'(go_s[d]), 0);
        end
        rst_n = 1'b1;

        // Basic run on channel 2
        expect_done(0, 2, 32);
        expect_done(1, 2, 32);
        pulse(4'b0100, 1'b0);
        check("s1_active2", int'(active_s[0][2]), 1);
        check("s1_frame_start", fr(0, 2), 0);
        ticks(7);
        check("s1_frame_t7", fr(0, 2), 0);
        ticks(1);
        check("s1_frame_t8", fr(0, 2), 1);
        ticks(8);
        check("s1_frame_t16", fr(0, 2), 2);
        ticks(8);
        check("s1_frame_t24", fr(1, 2), 3);
        ticks(8);
        check("s1_active2_end", int'(active_s[0][2]), 0);
        check("s1_frame_end", fr(0, 2), 0);

        // Player channel: game over on dut 0, plain idle on dut 1
        expect_done(0, 0, 64);
        expect_done(1, 0, 64);
        pulse(4'b0001, 1'b0);
        ticks(32);
        check("s2_go_dut0", int'(go_s[0]), 1);
        check("s2_active0_dut0", int'(active_s[0][0]), 0);
        check("s2_go_dut1", int'(go_s[1]), 0);
        expect_done(1, 0, 96);
        pulse(4'b0001, 1'b0);
        check("s2_ignored_active", int'(active_s[0][0]), 0);
        check("s2_ignored_go", int'(go_s[0]), 1);
        check("s2_dut1_restarted", int'(active_s[1][0]), 1);
        @(negedge clk);
        keycode = 16'h0004;
        @(negedge clk);
        check("s2_go_non_key", int'(go_s[0]), 1);
        keycode = 16'h2C00;
        @(negedge clk);
        check("s2_go_space", int'(go_s[0]), 0);
        keycode = 16'h0000;

        // Explode while running: ignored on dut 0, restart on dut 1
        expect_done(0, 1, 96);
        expect_done(1, 1, 106);
        pulse(4'b0010, 1'b0);
        ticks(10);
        check("s3_frame_t10_dut0", fr(0, 1), 1);
        check("s3_frame_t10_dut1", fr(1, 1), 1);
        pulse(4'b0010, 1'b0);
        check("s3_frame_after_dut0", fr(0, 1), 1);
        check("s3_frame_after_dut1", fr(1, 1), 0);
        ticks(8);
        check("s3_frame_t18_dut0", fr(0, 1), 2);
        check("s3_frame_t18_dut1", fr(1, 1), 1);
        ticks(24);

        // Explode on the finishing tick, then again in the done cycle
        expect_done(0, 3, 138);
        expect_done(0, 3, 170);
        expect_done(1, 3, 170);
        pulse(4'b1000, 1'b0);
        ticks(31);
        @(negedge clk);
        explode = 4'b1000;
        tick = 1'b1;
        n++;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        explode = '0;
        check("s4_rerun_active_dut0", int'(active_s[0][3]), 1);
        check("s4_rerun_frame_dut0", fr(0, 3), 0);
        check("s4_active_dut1", int'(active_s[1][3]), 1);
        ticks(32);

        // Staggered starts, some coinciding with a tick that must not count
        expect_done(0, 0, 203);
        expect_done(1, 0, 203);
        expect_done(0, 1, 205);
        expect_done(1, 1, 205);
        expect_done(0, 2, 205);
        expect_done(1, 2, 205);
        expect_done(0, 3, 207);
        expect_done(1, 3, 207);
        pulse(4'b0001, 1'b1);
        do_tick();
        pulse(4'b0010, 1'b1);
        pulse(4'b0100, 1'b0);
        do_tick();
        pulse(4'b1000, 1'b1);
        check("s5_all_active", int'(active_s[0]), 15);
        ticks(32);
        check("s5_go_dut0", int'(go_s[0]), 1);
        check("s5_all_idle_dut1", int'(active_s[1]), 0);
        @(negedge clk);
        keycode = 16'h0028;
        @(negedge clk);
        keycode = 16'h0000;
        check("s5_go_enter", int'(go_s[0]), 0);

        // Reset mid-sequence aborts without a done pulse
        pulse(4'b0010, 1'b0);
        ticks(20);
        check("s6_frame_before_rst", fr(0, 1), 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s6_active_after_rst", int'(active_s[0][1]), 0);
        check("s6_frame_after_rst", fr(0, 1), 0);
        ticks(40);

        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("pending dut%0d ch%0d", d, ch), exp_q[d][ch].size(), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/explosion_seq.md
Name: explosion_seq

Overview:
Parametrised multi-channel explosion animation sequencer for the Galaxian game. Each channel (player ship plus enemy slots) owns an independent sequence: a trigger pulse starts it, frames advance on the video-frame tick, and a one-cycle done pulse ends it. Channel 0 is the player: when PLAYER_GO=1 its sequence ends in a latched game-over state that clears only on a restart key. Sits between collision detection (explode requests) and the sprite/colour mapper (frame indices).

Parameters:
NUM_CH, 4, number of independent explosion channels (≥1); channel 0 is the player.
NUM_FRAMES, 4, animation frames per explosion (≥2).
FRAME_TICKS, 8, tick strobes each frame is held (≥1).
RETRIGGER, 0, 0 = explode while running is ignored; 1 = restart at frame 0.
PLAYER_GO, 1, 1 = channel 0 enters GAME_OVER after its last frame; 0 = returns to IDLE like other channels.

Ports:
Clk  input  1  system clock; sole clock of the block.
Reset  input  1  synchronous, active-low reset, sampled on rising Clk.
tick  input  1  one-Clk-cycle strobe per video frame (vsync-derived).
explode  input  NUM_CH  per-channel start request, sampled every Clk.
keycode  input  16  two USB HID keycodes, low byte and high byte.
active  output  NUM_CH  channel is in RUN.
frame_idx  output  NUM_CH*FW  per-channel frame index, channel i at [i*FW +: FW]; FW = max(1, $clog2(NUM_FRAMES)).
done  output  NUM_CH  one-cycle pulse when a channel finishes its last frame.
game_over  output  1  high while channel 0 is in GAME_OVER.

Behaviour:
- Reset low on a rising Clk: every channel goes to IDLE; tick_cnt=0, frame_idx=0, active=0, done=0, game_over=0. Reset mid-sequence aborts it with no done pulse.
- States per channel: IDLE, RUN, GAME_OVER (GAME_OVER reachable only on channel 0 with PLAYER_GO=1).
- IDLE: explode[i]=1 → RUN at the next edge, frame_idx=0, tick_cnt=0, active=1 (1 cycle latency). A tick in the same cycle is not counted.
- RUN: on tick, tick_cnt++; when tick_cnt==FRAME_TICKS-1 and tick=1, tick_cnt←0 and frame_idx++. Non-tick cycles hold all state.
- Last frame: tick that would advance past frame NUM_FRAMES-1 → done[i]=1 for exactly one cycle, active←0, frame_idx←0, state←IDLE (or GAME_OVER for channel 0 when PLAYER_GO=1). Total RUN duration = NUM_FRAMES*FRAME_TICKS ticks.
- explode in RUN: RETRIGGER=0 ignored; RETRIGGER=1 → frame_idx=0, tick_cnt=0, no done pulse. If explode coincides with the finishing tick: RETRIGGER=1 restarts (no done); RETRIGGER=0 finishes normally.
- explode in the done cycle (channel now IDLE) starts a new run on the following edge.
- GAME_OVER: game_over=1, active=0; explode[0] ignored. Restart when either keycode byte equals 8'h28 (Enter), 8'h2C (Space) or 8'h1A (W) → IDLE next edge, game_over=0. Key held on GAME_OVER entry cycle is honoured the next cycle.
- Channels are fully independent; simultaneous explode on all channels starts all of them.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- explosion_pkg: channel state enum (IDLE, RUN, GAME_OVER), restart keycode constants KEY_ENTER=8'h28, KEY_SPACE=8'h2C, KEY_W=8'h1A, and a function is_restart_key(keycode).
- Sub-module explosion_channel (parameters NUM_FRAMES, FRAME_TICKS, RETRIGGER, HAS_GO): one FSM + counters; top instantiates NUM_CH copies in a generate loop, HAS_GO=(i==0 && PLAYER_GO), and ORs restart decode into channel 0 only.

Test Plan:
- Defaults, Reset low 2 cycles then high → all outputs 0; explode[2] pulse → active[2]=1 next cycle, frame_idx ch2 steps 0,1,2,3 every 8 ticks, done[2] pulses once after tick 32, active[2]=0.
- explode[0] with PLAYER_GO=1 → after 32 ticks done[0]=1, game_over=1; explode[0] ignored; keycode=16'h2C00 → game_over=0 next cycle; keycode=16'h0004 → no effect.
- RETRIGGER=0: explode[1] again at tick 10 → ignored, done at tick 32; RETRIGGER=1: same stimulus → frame_idx=0 next cycle, done at tick 42.
- explode[3] in same cycle as finishing tick, RETRIGGER=0 → done[3]=1, then IDLE; pulse explode[3] on done cycle → RUN next edge.
- All four channels triggered at staggered cycles, tick and explode coinciding in IDLE → tick not counted; each channel's done timing independent.
- Reset asserted at frame 2 of channel 1 → active=0, frame_idx=0, no done pulse.
